rs_dsp_macc_pipe: RTL and testbench

//  Parametrised, pipelined signed/unsigned multiply-accumulate for the DSP38 flow; successor of the fixed 20x18 MULTACC reg-in/reg-out wrapper.

---
 rtl/rs_dsp_pkg.sv | 40 ++++
 rtl/rs_dsp_macc_pipe_if.sv | 37 +++
 rtl/rs_dsp_macc_post.sv | 113 +++++++++++
 rtl/rs_dsp_macc_pipe.sv | 155 +++++++++++++++
 tb/tb_rs_dsp_macc_pipe.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_dsp_pkg.sv
// Shared types and helpers for the rs_dsp_macc_pipe multiply-accumulate slice.
//   fb_mode_e   : accumulate mode encoding carried on the feedback field
//   prod_width  : width of the signed product of two sign/zero-extended operands
//   sat_clamp   : clamp a wide signed value into a signed field of a given width
package rs_dsp_pkg;

  typedef enum logic [2:0] {
    FB_ACC  = 3'd0,
    FB_LOAD = 3'd1,
    FB_HOLD = 3'd2
  } fb_mode_e;

  // Each operand gains one bit so unsigned inputs can be multiplied as signed.
  localparam int unsigned ProdExtBits = 2;

  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w + ProdExtBits;
  endfunction

  // Product width of the default 20x18 configuration.
  localparam int unsigned DefProdW = prod_width(20, 18);

  // Widest value the clamp helper accepts; callers sign-extend into it.
  localparam int unsigned SatMaxW = 128;
  typedef logic signed [SatMaxW-1:0] sat_val_t;

  function automatic sat_val_t sat_clamp(input sat_val_t value, input int unsigned width);
    sat_val_t hi;
    sat_val_t lo;
    hi = (sat_val_t'(1) <<< (width - 1)) - sat_val_t'(1);
    lo = -(sat_val_t'(1) <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/rs_dsp_macc_pipe_if.sv
// Sample/result bundle of rs_dsp_macc_pipe.
//   master : drives in_valid, operands and per-sample controls; receives out_valid, z, overflow
//   slave  : the MAC pipeline
interface rs_dsp_macc_pipe_if #(
  parameter int unsigned A_W   = 20,
  parameter int unsigned B_W   = 18,
  parameter int unsigned ACC_W = 38
) ();

  logic             in_valid;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             unsigned_a;
  logic             unsigned_b;
  logic [2:0]       feedback;
  logic             load_acc;
  logic             subtract;
  logic [5:0]       shift_right;
  logic             round;
  logic             saturate_enable;
  logic             out_valid;
  logic [ACC_W-1:0] z;
  logic             overflow;

  modport master (
    output in_valid, a, b, unsigned_a, unsigned_b, feedback, load_acc, subtract,
           shift_right, round, saturate_enable,
    input  out_valid, z, overflow
  );

  modport slave (
    input  in_valid, a, b, unsigned_a, unsigned_b, feedback, load_acc, subtract,
           shift_right, round, saturate_enable,
    output out_valid, z, overflow
  );

endinterface

// File: rtl/rs_dsp_macc_post.sv
// Output post-processing of the MAC: round half-up, arithmetic right shift, optional
// saturation to ACC_W, then an optional output register stage.
// Build option: RS_DSP_MACC_SAT_EN enables the clamp; without it overflow_o is 0 and
// z_o is always the truncated result.
// Ports:
//   clk, lreset   : clock, asynchronous active-high reset
//   vld_i         : accumulator value on acc_i is a fresh result
//   acc_i         : accumulator (AW bits, two's complement)
//   shift_i       : arithmetic right shift amount
//   round_i       : add half an LSB of the shifted result before shifting
//   sat_en_i      : clamp instead of truncate when out of the signed ACC_W range
//   out_valid_o   : z_o / overflow_o valid
//   z_o           : post-processed result
//   overflow_o    : clamp was applied to this result
module rs_dsp_macc_post
  import rs_dsp_pkg::*;
#(
  parameter int unsigned AW      = 46,
  parameter int unsigned ACC_W   = 38,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             lreset,
  input  logic             vld_i,
  input  logic [AW-1:0]    acc_i,
  input  logic [5:0]       shift_i,
  input  logic             round_i,
  input  logic             sat_en_i,
  output logic             out_valid_o,
  output logic [ACC_W-1:0] z_o,
  output logic             overflow_o
);

  // One extra bit so acc + rounding constant cannot wrap.
  localparam int unsigned RW = AW + 1;

  int unsigned          shamt;
  logic signed [RW-1:0] acc_sx;
  logic signed [RW-1:0] rnd_add;
  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] r;
  logic [ACC_W-1:0]     z_c;
  logic                 ovf_c;

  always_comb begin
    shamt   = 32'(shift_i);
    acc_sx  = {acc_i[AW-1], acc_i};
    rnd_add = '0;
    if (round_i && shamt != 0 && shamt < AW) begin
      rnd_add = RW'(1) << (shamt - 1);
    end
    sum = acc_sx + rnd_add;
    // Shifting by the full accumulator width or more leaves only sign bits.
    if (shamt >= AW) begin
      r = {RW{acc_i[AW-1]}};
    end else begin
      r = sum >>> shamt;
    end
  end

`ifdef RS_DSP_MACC_SAT_EN
  sat_val_t r_wide;
  sat_val_t r_clamp;
  logic     unused_post;

  always_comb begin
    r_wide  = sat_val_t'(r);
    r_clamp = sat_clamp(r_wide, ACC_W);
    ovf_c   = sat_en_i && (r_clamp != r_wide);
    z_c     = ovf_c ? r_clamp[ACC_W-1:0] : r[ACC_W-1:0];
  end

  assign unused_post = ^r_clamp[SatMaxW-1:ACC_W];
`else
  logic unused_post;

  always_comb begin
    ovf_c = 1'b0;
    z_c   = r[ACC_W-1:0];
  end

  assign unused_post = sat_en_i ^ (^r[RW-1:ACC_W]);
`endif

  if (OUT_REG != 0) begin : g_out_reg
    logic             vld_q;
    logic [ACC_W-1:0] z_q;
    logic             ovf_q;

    always_ff @(posedge clk or posedge lreset) begin
      if (lreset) begin
        vld_q <= 1'b0;
        z_q   <= '0;
        ovf_q <= 1'b0;
      end else begin
        vld_q <= vld_i;
        if (vld_i) begin
          z_q   <= z_c;
          ovf_q <= ovf_c;
        end
      end
    end

    assign out_valid_o = vld_q;
    assign z_o         = z_q;
    assign overflow_o  = ovf_q;
  end else begin : g_out_comb
    assign out_valid_o = vld_i;
    assign z_o         = z_c;
    assign overflow_o  = ovf_c;
  end

endmodule

// File: rtl/rs_dsp_macc_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with guard bits, feedback modes and
// round/shift/saturate post-processing. Stages: [input reg] -> mult+acc -> [output reg].
// Latency IN_REG+1+OUT_REG cycles; one result per valid input, no backpressure.
// Build option: RS_DSP_MACC_SAT_EN enables output saturation (see rs_dsp_macc_post).
// Ports:
//   clk     : clock, rising edge
//   lreset  : asynchronous active-high reset, clears every pipeline register and acc
//   bus     : slave side of rs_dsp_macc_pipe_if (sample in, result out)
module rs_dsp_macc_pipe
  import rs_dsp_pkg::*;
#(
  parameter int unsigned A_W     = 20,
  parameter int unsigned B_W     = 18,
  parameter int unsigned ACC_W   = 38,
  parameter int unsigned GUARD   = 8,
  parameter int unsigned IN_REG  = 1,
  parameter int unsigned OUT_REG = 1
) (
  input  logic              clk,
  input  logic              lreset,
  rs_dsp_macc_pipe_if.slave bus
);

  localparam int unsigned AW = ACC_W + GUARD;
  localparam int unsigned PW = prod_width(A_W, B_W);

  if (ACC_W < A_W + B_W) begin : g_chk_acc_w
    $fatal(1, "rs_dsp_macc_pipe: ACC_W=%0d must be >= A_W+B_W=%0d", ACC_W, A_W + B_W);
  end
  if (IN_REG > 1 || OUT_REG > 1) begin : g_chk_regs
    $fatal(1, "rs_dsp_macc_pipe: IN_REG and OUT_REG must be 0 or 1");
  end

  // Everything that belongs to one sample travels together.
  typedef struct packed {
    logic           vld;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           ua;
    logic           ub;
    logic [2:0]     fb;
    logic           load;
    logic           sub;
    logic [5:0]     sh;
    logic           rnd;
    logic           sat;
  } smp_t;

  smp_t smp_in;
  smp_t s1;

  always_comb begin
    smp_in.vld  = bus.in_valid;
    smp_in.a    = bus.a;
    smp_in.b    = bus.b;
    smp_in.ua   = bus.unsigned_a;
    smp_in.ub   = bus.unsigned_b;
    smp_in.fb   = bus.feedback;
    smp_in.load = bus.load_acc;
    smp_in.sub  = bus.subtract;
    smp_in.sh   = bus.shift_right;
    smp_in.rnd  = bus.round;
    smp_in.sat  = bus.saturate_enable;
  end

  if (IN_REG != 0) begin : g_in_reg
    smp_t in_q;

    // Payload only captured on valid beats; idle cycles just drop the valid bit.
    always_ff @(posedge clk or posedge lreset) begin
      if (lreset) begin
        in_q <= '0;
      end else if (smp_in.vld) begin
        in_q <= smp_in;
      end else begin
        in_q.vld <= 1'b0;
      end
    end

    assign s1 = in_q;
  end else begin : g_in_comb
    assign s1 = smp_in;
  end

  // Multiply + accumulate stage.
  logic signed [A_W:0]    a_ext;
  logic signed [B_W:0]    b_ext;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   p_sx;
  logic signed [AW-1:0]   p_term;
  logic signed [AW-1:0]   acc_d;
  logic signed [AW-1:0]   acc_q;
  logic                   acc_vld_q;
  logic [5:0]             sh_q;
  logic                   rnd_q;
  logic                   sat_q;

  always_comb begin
    a_ext  = {(s1.ua ? 1'b0 : s1.a[A_W-1]), s1.a};
    b_ext  = {(s1.ub ? 1'b0 : s1.b[B_W-1]), s1.b};
    prod   = a_ext * b_ext;
    p_sx   = AW'(prod);
    p_term = s1.sub ? -p_sx : p_sx;

    acc_d = acc_q;
    if (s1.vld) begin
      if (s1.load) begin
        acc_d = p_term;
      end else begin
        case (s1.fb)
          FB_LOAD: acc_d = p_term;
          FB_HOLD: acc_d = acc_q;
          // FB_ACC and the reserved codes 3..7
          default: acc_d = acc_q + p_term;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge lreset) begin
    if (lreset) begin
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      sh_q      <= '0;
      rnd_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_vld_q <= s1.vld;
      if (s1.vld) begin
        sh_q  <= s1.sh;
        rnd_q <= s1.rnd;
        sat_q <= s1.sat;
      end
    end
  end

  rs_dsp_macc_post #(
    .AW      (AW),
    .ACC_W   (ACC_W),
    .OUT_REG (OUT_REG)
  ) u_post (
    .clk         (clk),
    .lreset      (lreset),
    .vld_i       (acc_vld_q),
    .acc_i       (acc_q),
    .shift_i     (sh_q),
    .round_i     (rnd_q),
    .sat_en_i    (sat_q),
    .out_valid_o (bus.out_valid),
    .z_o         (bus.z),
    .overflow_o  (bus.overflow)
  );

endmodule

// File: tb/tb_rs_dsp_macc_pipe.sv
// Self-checking bench for rs_dsp_macc_pipe (default parameters, latency 3).
module tb_rs_dsp_macc_pipe;

  localparam int unsigned A_W   = 20;
  localparam int unsigned B_W   = 18;
  localparam int unsigned ACC_W = 38;
  localparam int unsigned GUARD = 8;
  localparam int unsigned AW    = ACC_W + GUARD;
  localparam int          L     = 3;
  localparam longint      P36   = 64'sd1 <<< 36;
  localparam longint      P37   = 64'sd1 <<< 37;
`ifdef RS_DSP_MACC_SAT_EN
  localparam bit SatBuild = 1'b1;
`else
  localparam bit SatBuild = 1'b0;
`endif

  logic clk = 1'b0;
  logic lreset = 1'b1;
  always #5 clk = ~clk;

  rs_dsp_macc_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();

  rs_dsp_macc_pipe #(
    .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .GUARD(GUARD), .IN_REG(1), .OUT_REG(1)
  ) dut (
    .clk    (clk),
    .lreset (lreset),
    .bus    (bus)
  );

  typedef struct {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    bit             ua;
    bit             ub;
    logic [2:0]     fb;
    bit             load;
    bit             sub;
    logic [5:0]     sh;
    bit             rnd;
    bit             sat;
  } beat_t;

  typedef struct {
    beat_t  bt;
    longint z;
    bit     ovf;
  } vec_t;

  typedef struct {
    longint z;
    bit     ovf;
    int     due;
    string  tag;
  } exp_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  exp_t   exp_q[$];
  longint m_acc = 0;

  function automatic longint sx(input longint v, input int w);
    longint m;
    m = v & ((64'sd1 <<< w) - 64'sd1);
    if (m >= (64'sd1 <<< (w - 1))) m -= 64'sd1 <<< w;
    return m;
  endfunction

  function automatic beat_t mk(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                               input bit ua, input bit ub, input logic [2:0] fb,
                               input bit load, input bit sub, input logic [5:0] sh,
                               input bit rnd, input bit sat);
    beat_t bt;
    bt.a = a; bt.b = b; bt.ua = ua; bt.ub = ub; bt.fb = fb;
    bt.load = load; bt.sub = sub; bt.sh = sh; bt.rnd = rnd; bt.sat = sat;
    return bt;
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    bt.a    = A_W'($urandom);
    bt.b    = B_W'($urandom);
    bt.ua   = 1'($urandom);
    bt.ub   = 1'($urandom);
    bt.fb   = 3'($urandom_range(0, 7));
    bt.load = ($urandom_range(0, 7) == 0);
    bt.sub  = 1'($urandom);
    bt.sh   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
    bt.rnd  = 1'($urandom);
    bt.sat  = 1'($urandom);
    return bt;
  endfunction

  // Reference: plain integer arithmetic on the mathematical values.
  function automatic void model_beat(input beat_t bt, output longint z, output bit ovf);
    longint av, bv, p, r, lim;
    int s;
    av = longint'(bt.a);
    if (!bt.ua && bt.a[A_W-1]) av -= 64'sd1 <<< A_W;
    bv = longint'(bt.b);
    if (!bt.ub && bt.b[B_W-1]) bv -= 64'sd1 <<< B_W;
    p = av * bv;
    if (bt.sub) p = -p;
    if (bt.load || bt.fb == 3'd1) m_acc = sx(p, AW);
    else if (bt.fb != 3'd2) m_acc = sx(m_acc + p, AW);
    s = int'(bt.sh);
    if (s >= int'(AW)) begin
      r = (m_acc < 0) ? -64'sd1 : 64'sd0;
    end else begin
      r = m_acc;
      if (bt.rnd && s > 0) r += 64'sd1 <<< (s - 1);
      r = r >>> s;
    end
    ovf = 1'b0;
    lim = 64'sd1 <<< (ACC_W - 1);
    if (SatBuild && bt.sat && r >= lim) begin
      r = lim - 1; ovf = 1'b1;
    end else if (SatBuild && bt.sat && r < -lim) begin
      r = -lim; ovf = 1'b1;
    end
    z = sx(r, ACC_W);
  endfunction

  task automatic drive(input beat_t bt, input bit vld);
    bus.in_valid        = vld;
    bus.a               = bt.a;
    bus.b               = bt.b;
    bus.unsigned_a      = bt.ua;
    bus.unsigned_b      = bt.ub;
    bus.feedback        = bt.fb;
    bus.load_acc        = bt.load;
    bus.subtract        = bt.sub;
    bus.shift_right     = bt.sh;
    bus.round           = bt.rnd;
    bus.saturate_enable = bt.sat;
  endtask

  // Advance one clock and check the output against the scoreboard.
  task automatic tick();
    exp_t   e;
    longint dz;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL %s out_valid: got %b want 1 (cycle %0d)", e.tag, bus.out_valid, cyc);
      end
      dz = sx(longint'(bus.z), ACC_W);
      n_cmp++;
      if (dz != e.z || bus.overflow !== e.ovf) begin
        n_bad++;
        $display("FAIL %s z/overflow: got z=%0d ovf=%b want z=%0d ovf=%b",
                 e.tag, dz, bus.overflow, e.z, e.ovf);
      end
    end else begin
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle out_valid: got %b want 0 (cycle %0d)", bus.out_valid, cyc);
      end
    end
  endtask

  task automatic send(input beat_t bt, input longint z, input bit ovf, input string tag);
    drive(bt, 1'b1);
    exp_q.push_back('{z: z, ovf: ovf, due: cyc + L, tag: tag});
    tick();
  endtask

  task automatic idle_tick();
    drive(rand_beat(), 1'b0);
    tick();
  endtask

  initial begin
    vec_t   tbl[$];
    beat_t  bt;
    longint ez;
    bit     eo;

    drive(mk('0, '0, 0, 0, 3'd0, 0, 0, 6'd0, 0, 0), 1'b0);
    lreset = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (bus.z !== '0 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got z=%h ovf=%b want z=0 ovf=0", bus.z, bus.overflow);
    end
    lreset = 1'b0;
    tick();

    // Directed vectors; accumulator state carries from one entry to the next.
    tbl.push_back('{mk(20'd3, 18'd5, 0, 0, 3'd0, 1, 0, 6'd0, 0, 0), 64'sd15, 1'b0});
    tbl.push_back('{mk(20'hFFFFE, 18'd4, 0, 0, 3'd0, 0, 0, 6'd0, 0, 0), 64'sd7, 1'b0});
    tbl.push_back('{mk(20'd9, 18'd9, 0, 0, 3'd2, 0, 0, 6'd2, 1, 0), 64'sd2, 1'b0});
    tbl.push_back('{mk(20'd9, 18'd9, 0, 0, 3'd2, 0, 0, 6'd2, 0, 0), 64'sd1, 1'b0});
    tbl.push_back('{mk(20'hFFFFF, 18'd1, 1, 0, 3'd0, 1, 0, 6'd0, 0, 0), 64'sd1048575, 1'b0});
    tbl.push_back('{mk(20'hFFFFF, 18'd1, 0, 0, 3'd0, 1, 0, 6'd0, 0, 0), -64'sd1, 1'b0});
    tbl.push_back('{mk(20'd100, 18'd1, 0, 0, 3'd0, 1, 0, 6'd0, 0, 0), 64'sd100, 1'b0});
    tbl.push_back('{mk(20'd10, 18'd3, 0, 0, 3'd0, 0, 1, 6'd0, 0, 0), 64'sd70, 1'b0});
    tbl.push_back('{mk(20'd10, 18'd3, 0, 0, 3'd1, 0, 1, 6'd0, 0, 0), -64'sd30, 1'b0});
    tbl.push_back('{mk(20'd2, 18'd3, 0, 0, 3'd5, 0, 0, 6'd0, 0, 0), -64'sd24, 1'b0});
    tbl.push_back('{mk(20'd7, 18'd7, 0, 0, 3'd2, 0, 0, 6'd63, 1, 0), -64'sd1, 1'b0});
    tbl.push_back('{mk(20'd4, 18'd4, 0, 0, 3'd2, 1, 0, 6'd0, 0, 0), 64'sd16, 1'b0});
    tbl.push_back('{mk(20'd7, 18'd7, 0, 0, 3'd2, 0, 0, 6'd46, 0, 0), 64'sd0, 1'b0});
    tbl.push_back('{mk(20'd1, 18'h3FFFF, 0, 1, 3'd0, 1, 0, 6'd0, 0, 0), 64'sd262143, 1'b0});
    tbl.push_back('{mk(20'hFFFFF, 18'h3FFFF, 0, 0, 3'd0, 1, 0, 6'd0, 0, 0), 64'sd1, 1'b0});
    tbl.push_back('{mk(20'h80000, 18'h20000, 1, 1, 3'd0, 1, 0, 6'd0, 0, 0), P36, 1'b0});
    tbl.push_back('{mk(20'h80000, 18'h20000, 1, 1, 3'd0, 0, 0, 6'd0, 0, 0), -P37, 1'b0});
    tbl.push_back('{mk(20'd1, 18'd1, 0, 0, 3'd0, 0, 1, 6'd0, 0, 0), P37 - 1, 1'b0});
    tbl.push_back('{mk(20'd1, 18'd1, 0, 0, 3'd0, 0, 0, 6'd0, 0, 1),
                    SatBuild ? P37 - 1 : -P37, SatBuild});
    tbl.push_back('{mk(20'h80000, 18'h20000, 0, 1, 3'd0, 1, 0, 6'd0, 0, 0), -P36, 1'b0});
    tbl.push_back('{mk(20'h80000, 18'h20000, 0, 1, 3'd0, 0, 0, 6'd0, 0, 1), -P37, 1'b0});
    tbl.push_back('{mk(20'd1, 18'd1, 0, 0, 3'd0, 0, 1, 6'd0, 0, 1),
                    SatBuild ? -P37 : P37 - 1, SatBuild});
    tbl.push_back('{mk(20'd5, 18'd5, 0, 0, 3'd2, 0, 0, 6'd37, 1, 0), -64'sd1, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      model_beat(tbl[i].bt, ez, eo);
      send(tbl[i].bt, tbl[i].z, tbl[i].ovf, $sformatf("vec%0d", i));
    end
    repeat (L + 1) idle_tick();

    // Random stream with gaps against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_tick();
      end else begin
        bt = rand_beat();
        model_beat(bt, ez, eo);
        send(bt, ez, eo, $sformatf("rnd%0d", i));
      end
    end
    repeat (L + 1) idle_tick();

    // Reset with the first result showing and two more beats in flight.
    for (int i = 0; i < 3; i++) begin
      bt = rand_beat();
      model_beat(bt, ez, eo);
      send(bt, ez, eo, $sformatf("pre_rst%0d", i));
    end
    lreset = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.z !== '0 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got out_valid=%b z=%h ovf=%b want 0/0/0",
               bus.out_valid, bus.z, bus.overflow);
    end
    exp_q.delete();
    m_acc = 0;
    drive(rand_beat(), 1'b1);
    repeat (2) tick();
    lreset = 1'b0;
    repeat (L + 2) idle_tick();
    bt = mk(20'd1, 18'd1, 0, 0, 3'd0, 0, 0, 6'd0, 0, 0);
    model_beat(bt, ez, eo);
    send(bt, 64'sd1, 1'b0, "post_rst_acc");
    repeat (L + 1) idle_tick();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d results outstanding want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
